// File: rtl/crc8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc8_seq_ctrl
// Description : Sequences frame bytes bit-serially (LSB first) into an
//               external serial CRC-8 engine. It reseeds the engine at the
//               start of each frame, then collects the 8 flushed CRC bits
//               into CRC_OUT. It aborts with an ERR pulse on input underrun
//               or on flush timeout.
//               Optional feature macro: CRC8_SEQ_CTRL_LEN_EN adds the
//               FRAME_LEN output, which reports the accepted byte count.
// Revision    : 1.0 - initial release
// ============================================================================
module crc8_seq_ctrl #(
   parameter int FLUSH_TMO = 16,
   parameter int LEN_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       IN_DATA,
   input  logic             IN_VALID,
   input  logic             IN_LAST,
   output logic             IN_READY,
   output logic             ENG_RST_N,
   output logic             ENG_DATA,
   output logic             ENG_ACTIVE,
   input  logic             ENG_CRC,
   input  logic             ENG_VALID,
   output logic [7:0]       CRC_OUT,
   output logic             CRC_OUT_VALID,
   output logic             ERR,
`ifdef CRC8_SEQ_CTRL_LEN_EN
   output logic [LEN_W-1:0] FRAME_LEN,
`endif
   output logic             BUSY
);

   localparam int TMO_W = $clog2(FLUSH_TMO + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SEED  = 3'd1,
      S_SHIFT = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic [7:0]       r_byte;
   logic             r_last;
   logic [2:0]       r_idx;
   logic [2:0]       r_bit_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic             r_in_ready;
   logic             r_eng_rst_n;
   logic             r_eng_data;
   logic             r_eng_active;
   logic [7:0]       r_crc_out;
   logic             r_crc_valid;
   logic             r_err;
   logic             r_busy;

   logic [2:0]       w_idx_nxt;
   logic             w_accept_first;
   logic             w_accept_next;
   logic             w_flush_done;

   assign w_idx_nxt      = r_idx + 3'd1;
   assign w_accept_first = (r_state == S_IDLE) && IN_VALID && r_in_ready;
   assign w_accept_next  = (r_state == S_SHIFT) && (r_idx == 3'd7) && !r_last && IN_VALID;
   assign w_flush_done   = (r_state == S_FLUSH) && ENG_VALID && (r_bit_cnt == 3'd7);

   // Main sequencer: state, bit index, CRC capture and all registered outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_byte       <= 8'd0;
         r_last       <= 1'b0;
         r_idx        <= 3'd0;
         r_bit_cnt    <= 3'd0;
         r_tmo        <= '0;
         r_in_ready   <= 1'b0;
         r_eng_rst_n  <= 1'b0;
         r_eng_data   <= 1'b0;
         r_eng_active <= 1'b0;
         r_crc_out    <= 8'd0;
         r_crc_valid  <= 1'b0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_crc_valid <= 1'b0;
         r_err       <= 1'b0;
         r_eng_rst_n <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_in_ready   <= 1'b1;
               r_eng_active <= 1'b0;
               r_eng_data   <= 1'b0;
               r_busy       <= 1'b0;
               if (w_accept_first) begin
                  r_byte      <= IN_DATA;
                  r_last      <= IN_LAST;
                  r_in_ready  <= 1'b0;
                  r_eng_rst_n <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= S_SEED;
               end
            end
            S_SEED: begin
               r_idx        <= 3'd0;
               r_eng_active <= 1'b1;
               r_eng_data   <= r_byte[0];
               r_state      <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_idx != 3'd7) begin
                  r_idx      <= w_idx_nxt;
                  r_eng_data <= r_byte[w_idx_nxt];
                  // Ready is offered only on the final bit of a non-last byte
                  r_in_ready <= (w_idx_nxt == 3'd7) && !r_last;
               end else if (r_last) begin
                  r_eng_active <= 1'b0;
                  r_eng_data   <= 1'b0;
                  r_bit_cnt    <= 3'd0;
                  r_tmo        <= '0;
                  r_state      <= S_FLUSH;
               end else if (IN_VALID) begin
                  // Seamless hand-over: the engine keeps shifting with no gap
                  r_byte     <= IN_DATA;
                  r_last     <= IN_LAST;
                  r_idx      <= 3'd0;
                  r_eng_data <= IN_DATA[0];
                  r_in_ready <= 1'b0;
               end else begin
                  // Underrun: the frame cannot continue, abort it
                  r_err        <= 1'b1;
                  r_eng_active <= 1'b0;
                  r_eng_data   <= 1'b0;
                  r_busy       <= 1'b0;
                  r_in_ready   <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            S_FLUSH: begin
               if (ENG_VALID) begin
                  // CRC_OUT holds the previous frame's value until the first new bit
                  if (r_bit_cnt == 3'd0) begin
                     r_crc_out <= {7'd0, ENG_CRC};
                  end else begin
                     r_crc_out[r_bit_cnt] <= ENG_CRC;
                  end
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               if (w_flush_done) begin
                  r_crc_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_tmo == TMO_W'(FLUSH_TMO - 1)) begin
                  r_err      <= 1'b1;
                  r_busy     <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            S_DONE: begin
               r_busy     <= 1'b0;
               r_in_ready <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CRC8_SEQ_CTRL_LEN_EN
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_frame_len;

   // Per-frame accepted-byte counter, saturating at all-ones
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_len <= '0;
      end else if (w_accept_first) begin
         r_len <= LEN_W'(1);
      end else if (w_accept_next && !(&r_len)) begin
         r_len <= r_len + LEN_W'(1);
      end
   end

   // Publish the byte count alongside CRC_OUT_VALID
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_frame_len <= '0;
      end else if (w_flush_done) begin
         r_frame_len <= r_len;
      end
   end

   assign FRAME_LEN = r_frame_len;
`endif

   assign IN_READY      = r_in_ready;
   assign ENG_RST_N     = r_eng_rst_n;
   assign ENG_DATA      = r_eng_data;
   assign ENG_ACTIVE    = r_eng_active;
   assign CRC_OUT       = r_crc_out;
   assign CRC_OUT_VALID = r_crc_valid;
   assign ERR           = r_err;
   assign BUSY          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_crc8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc8_seq_ctrl
// Description : Directed self-checking bench for crc8_seq_ctrl. The bench
//               drives the serial engine inputs (ENG_CRC/ENG_VALID) directly.
//               FRAME_LEN is checked when CRC8_SEQ_CTRL_LEN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc8_seq_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       eng_rst_n;
   logic       eng_data;
   logic       eng_active;
   logic       eng_crc;
   logic       eng_valid;
   logic [7:0] crc_out;
   logic       crc_out_valid;
   logic       err;
   logic       busy;
`ifdef CRC8_SEQ_CTRL_LEN_EN
   logic [7:0] frame_len;
`endif

   int checks = 0;
   int errors = 0;

   crc8_seq_ctrl #(.FLUSH_TMO(16), .LEN_W(8)) dut (
      .CLK           (clk),
      .RST           (rst),
      .IN_DATA       (in_data),
      .IN_VALID      (in_valid),
      .IN_LAST       (in_last),
      .IN_READY      (in_ready),
      .ENG_RST_N     (eng_rst_n),
      .ENG_DATA      (eng_data),
      .ENG_ACTIVE    (eng_active),
      .ENG_CRC       (eng_crc),
      .ENG_VALID     (eng_valid),
      .CRC_OUT       (crc_out),
      .CRC_OUT_VALID (crc_out_valid),
      .ERR           (err),
`ifdef CRC8_SEQ_CTRL_LEN_EN
      .FRAME_LEN     (frame_len),
`endif
      .BUSY          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0;
      eng_crc = 1'b0; eng_valid = 1'b0;
      tick; tick;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      checks++; if (eng_rst_n !== 1'b0) begin errors++; $display("FAIL rst_eng_rst_n got %b want 0", eng_rst_n); end
      checks++; if ({eng_active, eng_data} !== 2'b00) begin errors++; $display("FAIL rst_eng_act_data got %b want 00", {eng_active, eng_data}); end
      checks++; if (crc_out !== 8'h00) begin errors++; $display("FAIL rst_crc_out got %h want 00", crc_out); end
      checks++; if ({crc_out_valid, err, busy} !== 3'b000) begin errors++; $display("FAIL rst_valid_err_busy got %b want 000", {crc_out_valid, err, busy}); end
`ifdef CRC8_SEQ_CTRL_LEN_EN
      checks++; if (frame_len !== 8'd0) begin errors++; $display("FAIL rst_frame_len got %0d want 0", frame_len); end
`endif
      rst = 1'b0;
      tick;
      checks++; if ({in_ready, eng_rst_n, busy} !== 3'b110) begin errors++; $display("FAIL post_rst_ready_rstn_busy got %b want 110", {in_ready, eng_rst_n, busy}); end
   endtask

   // Single byte 0xA5 then CRC bits 1,1,0,0,0,0,0,0 -> 0x03
   task automatic test_single_byte;
      logic [7:0] b;
      logic [7:0] c;
      b = 8'hA5; c = 8'h03;
      in_data = 8'hA5; in_valid = 1'b1; in_last = 1'b1;
      tick;
      checks++; if ({eng_rst_n, busy, in_ready, eng_active} !== 4'b0100) begin errors++; $display("FAIL single_seed got %b want 0100", {eng_rst_n, busy, in_ready, eng_active}); end
      in_data = 8'hFF;
      tick;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if ({eng_active, eng_data, in_ready, eng_rst_n} !== {1'b1, b[i], 1'b0, 1'b1}) begin errors++; $display("FAIL single_shift%0d got %b want %b", i, {eng_active, eng_data, in_ready, eng_rst_n}, {1'b1, b[i], 1'b0, 1'b1}); end
         tick;
      end
      checks++; if ({eng_active, busy} !== 2'b01) begin errors++; $display("FAIL single_flush_entry got %b want 01", {eng_active, busy}); end
      eng_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         eng_crc = c[i];
         checks++; if (crc_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid%0d got %b want 0", i, crc_out_valid); end
         tick;
      end
      eng_valid = 1'b0; eng_crc = 1'b0;
      checks++; if ({crc_out_valid, crc_out} !== {1'b1, 8'h03}) begin errors++; $display("FAIL single_crc got %b/%h want 1/03", crc_out_valid, crc_out); end
`ifdef CRC8_SEQ_CTRL_LEN_EN
      checks++; if (frame_len !== 8'd1) begin errors++; $display("FAIL single_frame_len got %0d want 1", frame_len); end
`endif
      tick;
      checks++; if ({crc_out_valid, busy, in_ready, crc_out} !== {3'b001, 8'h03}) begin errors++; $display("FAIL single_idle got %b/%h want 001/03", {crc_out_valid, busy, in_ready}, crc_out); end
   endtask

   // Bytes 0x01, 0x80 with IN_VALID held: 16 gapless shift cycles
   task automatic test_back_to_back;
      logic [15:0] s;
      logic [7:0]  c;
      s = 16'h8001; c = 8'hAA;
      in_data = 8'h01; in_valid = 1'b1; in_last = 1'b0;
      tick;
      in_data = 8'h80; in_last = 1'b1;
      tick;
      for (int i = 0; i < 16; i++) begin
         checks++; if ({eng_active, eng_data, in_ready} !== {1'b1, s[i], (i == 7)}) begin errors++; $display("FAIL b2b_shift%0d got %b want %b", i, {eng_active, eng_data, in_ready}, {1'b1, s[i], (i == 7)}); end
         if (i == 0) begin
            checks++; if (crc_out !== 8'h03) begin errors++; $display("FAIL b2b_crc_hold got %h want 03", crc_out); end
         end
         if (i == 8) in_valid = 1'b0;
         tick;
      end
      checks++; if (eng_active !== 1'b0) begin errors++; $display("FAIL b2b_flush_entry got %b want 0", eng_active); end
      eng_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         eng_crc = c[i];
         tick;
      end
      eng_valid = 1'b0; eng_crc = 1'b0;
      checks++; if ({crc_out_valid, crc_out} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL b2b_crc got %b/%h want 1/aa", crc_out_valid, crc_out); end
`ifdef CRC8_SEQ_CTRL_LEN_EN
      checks++; if (frame_len !== 8'd2) begin errors++; $display("FAIL b2b_frame_len got %0d want 2", frame_len); end
`endif
      tick;
   endtask

   // Byte 0x55 not last, nothing follows at index 7 -> ERR
   task automatic test_underrun;
      logic [7:0] b;
      b = 8'h55;
      in_data = 8'h55; in_valid = 1'b1; in_last = 1'b0;
      tick;
      in_valid = 1'b0;
      tick;
      for (int i = 0; i < 8; i++) begin
         checks++; if ({eng_active, eng_data, in_ready} !== {1'b1, b[i], (i == 7)}) begin errors++; $display("FAIL underrun_shift%0d got %b want %b", i, {eng_active, eng_data, in_ready}, {1'b1, b[i], (i == 7)}); end
         tick;
      end
      checks++; if ({err, busy, crc_out_valid, eng_active} !== 4'b1000) begin errors++; $display("FAIL underrun_abort got %b want 1000", {err, busy, crc_out_valid, eng_active}); end
      checks++; if (crc_out !== 8'hAA) begin errors++; $display("FAIL underrun_crc_hold got %h want aa", crc_out); end
      tick;
      checks++; if ({err, in_ready, crc_out_valid} !== 3'b010) begin errors++; $display("FAIL underrun_idle got %b want 010", {err, in_ready, crc_out_valid}); end
   endtask

   // No CRC bits for 16 FLUSH cycles -> ERR; stray strobes must be ignored
   task automatic test_flush_timeout;
      in_data = 8'h00; in_valid = 1'b1; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      eng_valid = 1'b1; eng_crc = 1'b1;
      tick;
      for (int i = 0; i < 8; i++) tick;
      eng_valid = 1'b0; eng_crc = 1'b0;
      checks++; if (crc_out !== 8'hAA) begin errors++; $display("FAIL tmo_eng_valid_ignored got %h want aa", crc_out); end
      for (int k = 0; k < 16; k++) begin
         in_valid = (k < 8);
         checks++; if ({err, busy, eng_active, in_ready} !== 4'b0100) begin errors++; $display("FAIL tmo_flush%0d got %b want 0100", k, {err, busy, eng_active, in_ready}); end
         tick;
      end
      in_valid = 1'b0;
      checks++; if ({err, busy, crc_out_valid} !== 3'b100) begin errors++; $display("FAIL tmo_abort got %b want 100", {err, busy, crc_out_valid}); end
      checks++; if (crc_out !== 8'hAA) begin errors++; $display("FAIL tmo_crc_hold got %h want aa", crc_out); end
      tick;
      checks++; if ({err, in_ready} !== 2'b01) begin errors++; $display("FAIL tmo_idle got %b want 01", {err, in_ready}); end
   endtask

   // Reset at shift index 3, then a clean frame 0x3C with CRC 0x81
   task automatic test_mid_reset;
      logic [7:0] b;
      logic [7:0] c;
      b = 8'h3C; c = 8'h81;
      in_data = 8'hF0; in_valid = 1'b1; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick; tick; tick;
      rst = 1'b1;
      tick;
      checks++; if ({in_ready, eng_rst_n, eng_active, eng_data} !== 4'b0000) begin errors++; $display("FAIL midrst_eng got %b want 0000", {in_ready, eng_rst_n, eng_active, eng_data}); end
      checks++; if ({crc_out_valid, err, busy, crc_out} !== {3'b000, 8'h00}) begin errors++; $display("FAIL midrst_out got %b/%h want 000/00", {crc_out_valid, err, busy}, crc_out); end
      rst = 1'b0;
      tick;
      checks++; if ({in_ready, err, crc_out_valid} !== 3'b100) begin errors++; $display("FAIL midrst_release got %b want 100", {in_ready, err, crc_out_valid}); end
      in_data = 8'h3C; in_valid = 1'b1; in_last = 1'b1;
      tick;
      in_valid = 1'b0;
      checks++; if ({eng_rst_n, busy} !== 2'b01) begin errors++; $display("FAIL midrst_seed got %b want 01", {eng_rst_n, busy}); end
      tick;
      for (int i = 0; i < 8; i++) begin
         checks++; if ({eng_active, eng_data} !== {1'b1, b[i]}) begin errors++; $display("FAIL midrst_shift%0d got %b want %b", i, {eng_active, eng_data}, {1'b1, b[i]}); end
         tick;
      end
      eng_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         eng_crc = c[i];
         tick;
      end
      eng_valid = 1'b0; eng_crc = 1'b0;
      checks++; if ({crc_out_valid, crc_out} !== {1'b1, 8'h81}) begin errors++; $display("FAIL midrst_crc got %b/%h want 1/81", crc_out_valid, crc_out); end
`ifdef CRC8_SEQ_CTRL_LEN_EN
      checks++; if (frame_len !== 8'd1) begin errors++; $display("FAIL midrst_frame_len got %0d want 1", frame_len); end
`endif
      tick;
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_underrun;
      test_flush_timeout;
      test_mid_reset;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
